// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared occupancy state encoding for pipe_skid_buf
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_MAIN  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    localparam pipe_state_t PS_RST = PS_EMPTY;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - sync-reset load-enable payload register (main or skid slot)
module pipe_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (ld) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry registered valid/ready skid buffer; PIPE_SKID_INIT_EN adds test preload
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
`ifdef PIPE_SKID_INIT_EN
    input  logic             init,
    input  logic             init_valid,
    input  logic [WIDTH-1:0] init_data,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    pipe_state_t      state;
    pipe_state_t      state_next;
    logic             in_fire;
    logic             out_fire;
    logic             main_ld;
    logic             skid_ld;
    logic [WIDTH-1:0] main_din;
    logic [WIDTH-1:0] skid_din;
    logic [WIDTH-1:0] skid_dout;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Handshake flags are flops computed from the next state, so out_ready
    // never reaches in_ready within a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PS_RST;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next != PS_EMPTY);
            in_ready  <= (state_next != PS_FULL);
        end
    end

    always_comb begin
        state_next = state;
        main_ld    = 1'b0;
        skid_ld    = 1'b0;
        main_din   = in_data;
        skid_din   = in_data;
`ifdef PIPE_SKID_INIT_EN
        if (init) begin
            main_ld    = 1'b1;
            main_din   = init_data;
            skid_ld    = 1'b1;
            skid_din   = '0;
            state_next = init_valid ? PS_MAIN : PS_EMPTY;
        end else
`endif
        if (flush) begin
            state_next = PS_EMPTY;
        end else begin
            unique case (state)
                PS_EMPTY: begin
                    if (in_fire) begin
                        main_ld    = 1'b1;
                        state_next = PS_MAIN;
                    end
                end
                PS_MAIN: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        skid_ld    = 1'b1;
                        state_next = PS_FULL;
                    end else if (out_fire) begin
                        state_next = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (out_fire) begin
                        main_ld    = 1'b1;
                        main_din   = skid_dout;
                        state_next = PS_MAIN;
                    end
                end
                default: state_next = PS_RST;
            endcase
        end
    end

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .clk  (clk),
        .rst  (rst),
        .ld   (main_ld),
        .din  (main_din),
        .dout (out_data)
    );

    pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .ld   (skid_ld),
        .din  (skid_din),
        .dout (skid_dout)
    );

endmodule

// File: tb/tb_pipe_skid_buf.sv
// tb/tb_pipe_skid_buf.sv - self-checking bench for pipe_skid_buf
module tb_pipe_skid_buf;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_SKID_INIT_EN
    logic         init;
    logic         init_valid;
    logic [W-1:0] init_data;
`endif

    always #5 clk = ~clk;

    pipe_skid_buf #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
`ifdef PIPE_SKID_INIT_EN
        .init      (init),
        .init_valid(init_valid),
        .init_data (init_data),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         rst;
        logic         flush;
        logic         iv;
        logic         ordy;
        logic [W-1:0] din;
        logic         eov;
        logic         eir;
        logic [W-1:0] eod;
        bit           chk_od;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic f, input logic iv, input logic ordy,
                                input logic [W-1:0] din, input logic eov, input logic eir,
                                input logic [W-1:0] eod, input bit chk_od);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy; v.din = din;
        v.eov = eov; v.eir = eir; v.eod = eod; v.chk_od = chk_od;
        vecs.push_back(v);
    endfunction

    logic [W-1:0] q[$];
    logic         ir_m;
    logic         in_f;
    logic         out_f;
    logic         ir_before;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef PIPE_SKID_INIT_EN
        init = 1'b0; init_valid = 1'b0; init_data = '0;
`endif
        // reset, then release
        add(1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 1, 32'h77, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1);
        // streaming 1..8 at full rate, then drain
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 1, k, 1, 1, k, 1);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0);
        // stall fills main then skid, in_valid ignored while full
        add(0, 0, 1, 0, 32'hA, 1, 1, 32'hA, 1);
        add(0, 0, 1, 0, 32'hB, 1, 0, 32'hA, 1);
        add(0, 0, 1, 0, 32'hD, 1, 0, 32'hA, 1);
        add(0, 0, 0, 1, 0, 1, 1, 32'hB, 1);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0);
        // flush while full with a same-cycle offer
        add(0, 0, 1, 0, 32'hA, 1, 1, 32'hA, 1);
        add(0, 0, 1, 0, 32'hB, 1, 0, 32'hA, 1);
        add(0, 1, 1, 0, 32'hC, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0);
        // flush from MAIN with simultaneous in_fire and out_fire
        add(0, 0, 1, 0, 32'h11, 1, 1, 32'h11, 1);
        add(0, 1, 1, 1, 32'h22, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0);

        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].iv;
            out_ready = vecs[i].ordy; in_data = vecs[i].din;
            tick();
            check($sformatf("vec%0d out_valid", i), W'(out_valid), W'(vecs[i].eov));
            check($sformatf("vec%0d in_ready", i), W'(in_ready), W'(vecs[i].eir));
            if (vecs[i].chk_od) check($sformatf("vec%0d out_data", i), out_data, vecs[i].eod);
        end

        // randomized traffic against a queue model
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        q.delete();
        ir_m = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            flush     = ($urandom_range(0, 99) < 2);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            if (n % 250 == 0) begin
                ir_before = in_ready;
                out_ready = ~out_ready;
                #1;
                check("comb in_ready vs out_ready", W'(in_ready), W'(ir_before));
                out_ready = ~out_ready;
                #1;
            end
            in_f  = in_valid && ir_m;
            out_f = out_ready && (q.size() > 0);
            tick();
            if (flush) begin
                q.delete();
                ir_m = 1'b1;
            end else begin
                if (out_f) void'(q.pop_front());
                if (in_f) q.push_back(in_data);
                ir_m = (q.size() < 2);
            end
            check("rand out_valid", W'(out_valid), W'(q.size() > 0));
            check("rand in_ready", W'(in_ready), W'(ir_m));
            if (q.size() > 0) check("rand out_data", out_data, q[0]);
        end

`ifdef PIPE_SKID_INIT_EN
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        in_data = 32'hA; tick();
        in_data = 32'hB; tick();
        check("init pre full in_ready", W'(in_ready), W'(1'b0));
        in_valid = 1'b0; init = 1'b1; init_valid = 1'b1; init_data = 32'h55;
        tick();
        init = 1'b0;
        check("init out_data", out_data, 32'h55);
        check("init out_valid", W'(out_valid), W'(1'b1));
        check("init in_ready", W'(in_ready), W'(1'b1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
